// File: rtl/gcd_pkg.sv
// Shared types for the GCD operand sequencer: state encoding, widths and the
// timeout counter type.
package gcd_pkg;

    localparam int GCD_W = 8;
    localparam int TMO_W = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CLR  = 3'd1,
        S_LDA  = 3'd2,
        S_LDB  = 3'd3,
        S_WAIT = 3'd4,
        S_RESP = 3'd5
    } state_t;

    typedef logic [TMO_W-1:0] tmo_cnt_t;

endpackage

// File: rtl/gcd_pair_fifo.sv
// Synchronous FIFO holding {A,B} operand pairs; head entry is visible on
// rd_data whenever the FIFO is non-empty.
module gcd_pair_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wr_ptr;
    ptr_t             rd_ptr;
    cnt_t             count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_pop)  rd_ptr <= rd_ptr + ptr_t'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + cnt_t'(1);
                2'b01:   count <= count - cnt_t'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == cnt_t'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/gcd_operand_sequencer.sv
// Front end for the subtractive GCD core: queues operand pairs, loads the core
// over its shared bus (A then B), waits for done or timeout, returns the result.
module gcd_operand_sequencer
    import gcd_pkg::*;
#(
    parameter int W       = GCD_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         core_rst,
    output logic         core_start,
    output logic [W-1:0] core_data,
    input  logic         core_done,
    input  logic [W-1:0] core_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_gcd,
    output logic         out_err,
    output logic         busy
);

    localparam tmo_cnt_t TMO_LIMIT = tmo_cnt_t'(TIMEOUT);

    function automatic tmo_cnt_t sat_inc(input tmo_cnt_t c);
        return (c == '1) ? c : c + tmo_cnt_t'(1);
    endfunction

    state_t         state;
    tmo_cnt_t       tmo_cnt;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;

    logic           fifo_push;
    logic           fifo_pop;
    logic           fifo_full;
    logic           fifo_empty;
    logic [2*W-1:0] fifo_head;
    logic [W-1:0]   head_a;
    logic [W-1:0]   head_b;
    logic           head_has_zero;

    assign in_ready      = !fifo_full;
    assign fifo_push     = in_valid && in_ready;
    assign fifo_pop      = (state == S_IDLE) && !fifo_empty;
    assign head_a        = fifo_head[2*W-1:W];
    assign head_b        = fifo_head[W-1:0];
    assign head_has_zero = (head_a == '0) || (head_b == '0);

    gcd_pair_fifo #(
        .WIDTH (2*W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data ({in_a, in_b}),
        .pop     (fifo_pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Operand holding registers are pure data and never need a reset value.
    always_ff @(posedge clk) begin
        if (fifo_pop) begin
            op_a <= head_a;
            op_b <= head_b;
        end
    end

    // Every output is registered and assigned on the transition into the
    // state that owns it, so it is valid for exactly that state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            tmo_cnt    <= '0;
            core_rst   <= 1'b0;
            core_start <= 1'b0;
            core_data  <= '0;
            out_valid  <= 1'b0;
            out_gcd    <= '0;
            out_err    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            core_rst   <= 1'b0;
            core_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        busy <= 1'b1;
                        if (head_has_zero) begin
                            // gcd(0,x)=x; the subtractive core would never finish.
                            out_gcd   <= head_a | head_b;
                            out_err   <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            core_rst <= 1'b1;
                            state    <= S_CLR;
                        end
                    end
                end
                S_CLR: begin
                    core_start <= 1'b1;
                    core_data  <= op_a;
                    state      <= S_LDA;
                end
                S_LDA: begin
                    core_data <= op_b;
                    tmo_cnt   <= '0;
                    state     <= S_LDB;
                end
                S_LDB: begin
                    tmo_cnt <= sat_inc(tmo_cnt);
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the timeout cycle still counts as success.
                    if (core_done) begin
                        out_gcd   <= core_result;
                        out_err   <= 1'b0;
                        out_valid <= 1'b1;
                        core_data <= '0;
                        state     <= S_RESP;
                    end else if (tmo_cnt >= TMO_LIMIT) begin
                        out_gcd   <= '0;
                        out_err   <= 1'b1;
                        out_valid <= 1'b1;
                        core_data <= '0;
                        state     <= S_RESP;
                    end else begin
                        tmo_cnt <= sat_inc(tmo_cnt);
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    core_data <= '0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_operand_sequencer.sv
// Directed-plus-random bench for gcd_operand_sequencer with a behavioural GCD
// core (done N cycles after the B load) and a queue-based result reference.
module tb_gcd_operand_sequencer;

    localparam int W       = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 255;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         core_rst;
    logic         core_start;
    logic [W-1:0] core_data;
    logic         core_done;
    logic [W-1:0] core_result;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_gcd;
    logic         out_err;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    gcd_operand_sequencer #(.W(W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .core_rst    (core_rst),
        .core_start  (core_start),
        .core_data   (core_data),
        .core_done   (core_done),
        .core_result (core_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_gcd     (out_gcd),
        .out_err     (out_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int ref_gcd(input int a, input int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Behavioural core: latches A on the start strobe, B the cycle after,
    // then raises done n_lat cycles after the B-load cycle until re-initialised.
    int           n_lat    = 5;
    bit           hang     = 1'b0;
    bit           stale_en = 1'b0;
    logic [W-1:0] m_a, m_b;
    bit           m_ldb    = 1'b0;
    bit           m_armed  = 1'b0;
    int           m_due    = 0;
    logic         stale_now;

    always @(posedge clk) begin
        if (rst || core_rst) begin
            m_ldb   <= 1'b0;
            m_armed <= 1'b0;
        end else if (core_start) begin
            m_a     <= core_data;
            m_ldb   <= 1'b1;
            m_armed <= 1'b0;
        end else if (m_ldb) begin
            m_b     <= core_data;
            m_ldb   <= 1'b0;
            m_armed <= 1'b1;
            m_due   <= cyc + n_lat;
        end
    end

    assign stale_now   = stale_en && (core_start || m_ldb);
    assign core_done   = stale_now || (m_armed && !hang && (cyc >= m_due));
    assign core_result = stale_now ? 8'hEE :
                         (m_armed ? W'(ref_gcd(int'(m_a), int'(m_b))) : '0);

    // Monitors
    int           starts = 0, rsts = 0;
    int           lda_cyc = 0, ldb_cyc = 0, vrise_cyc = 0, push_cyc = 0;
    logic [W-1:0] lda_data, ldb_data;
    bit           prev_v = 1'b0;
    logic [W:0]   got_q[$];
    logic [W:0]   exp_q[$];
    int           got_rd = 0;

    always @(posedge clk) begin
        prev_v <= (out_valid === 1'b1);
        if (core_start === 1'b1) begin
            starts   <= starts + 1;
            lda_cyc  <= cyc;
            lda_data <= core_data;
        end
        if (m_ldb) begin
            ldb_cyc  <= cyc;
            ldb_data <= core_data;
        end
        if (core_rst === 1'b1) rsts <= rsts + 1;
        if (out_valid === 1'b1 && !prev_v) vrise_cyc <= cyc;
        if (in_valid && in_ready === 1'b1) push_cyc <= cyc;
        if (!rst && out_valid === 1'b1 && out_ready) got_q.push_back({out_err, out_gcd});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int a, input int b, input bit expect_err);
        bit ok = 1'b0;
        exp_q.push_back(expect_err ? {1'b1, {W{1'b0}}} : {1'b0, W'(ref_gcd(a, b))});
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = W'(a);
            in_b     = W'(b);
            if (in_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        #1 in_valid = 1'b0;
        if (!ok) chk("push_accept", 32'(ok), 1);
    endtask

    task automatic wait_results(input string tag, input int n);
        int budget = 3000;
        while (got_q.size() < got_rd + n && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        for (int i = 0; i < n; i++) begin
            if (got_rd < got_q.size() && exp_q.size() > 0) begin
                chk(tag, 32'(got_q[got_rd]), 32'(exp_q.pop_front()));
                got_rd++;
            end else begin
                chk({tag, "_missing"}, 32'(got_q.size() - got_rd), 32'(n - i));
            end
        end
    endtask

    initial begin
        int s0, r0, g0, a, b;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_core_start", 32'(core_start), 0);
        chk("rst_core_rst", 32'(core_rst), 0);
        chk("rst_core_data", 32'(core_data), 0);
        chk("rst_out_gcd", 32'({out_err, out_gcd}), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 1);

        // 1: basic (12,18), N=5
        n_lat = 5;
        s0 = starts;
        push(12, 18, 1'b0);
        wait_results("t1_result", 1);
        chk("t1_starts", 32'(starts - s0), 1);
        chk("t1_data_a", 32'(lda_data), 12);
        chk("t1_data_b", 32'(ldb_data), 18);
        chk("t1_latency", 32'(vrise_cyc - lda_cyc), 32'(n_lat + 2));
        @(negedge clk);
        chk("t1_core_data_idle", 32'(core_data), 0);

        // 2: zero bypass, no core activity
        s0 = starts;
        r0 = rsts;
        push(0, 7, 1'b0);
        wait_results("t2_result_0_7", 1);
        chk("t2_bypass_latency", 32'(vrise_cyc - push_cyc), 2);
        push(0, 0, 1'b0);
        wait_results("t2_result_0_0", 1);
        chk("t2_no_start", 32'(starts - s0), 0);
        chk("t2_no_core_rst", 32'(rsts - r0), 0);

        // 3: backpressure, 1 in flight + DEPTH queued
        out_ready = 1'b0;
        n_lat = 2;
        for (int i = 0; i < 5; i++) begin
            a = int'($urandom_range(1, 255));
            b = int'($urandom_range(1, 255));
            push(a, b, 1'b0);
        end
        @(negedge clk);
        chk("t3_full_in_ready", 32'(in_ready), 0);
        repeat (20) @(negedge clk);
        chk("t3_still_full", 32'(in_ready), 0);
        chk("t3_resp_held", 32'(out_valid), 1);
        out_ready = 1'b1;
        wait_results("t3_order", 5);

        // 4: hung core -> timeout abort 256 cycles after LDB
        hang = 1'b1;
        push(10, 4, 1'b1);
        wait_results("t4_abort", 1);
        chk("t4_abort_latency", 32'(vrise_cyc - ldb_cyc), 256);
        hang = 1'b0;

        // done on the very cycle the timeout would fire: done wins
        n_lat = TIMEOUT;
        push(200, 150, 1'b0);
        wait_results("t4b_done_wins", 1);
        chk("t4b_latency", 32'(vrise_cyc - ldb_cyc), 256);

        // 5: reset during WAIT with two pairs queued
        n_lat = 50;
        push(30, 45, 1'b0);
        push(14, 21, 1'b0);
        push(16, 24, 1'b0);
        repeat (10) @(negedge clk);
        chk("t5_busy_before", 32'(busy), 1);
        g0 = got_q.size();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("t5_out_valid", 32'(out_valid), 0);
        chk("t5_busy", 32'(busy), 0);
        chk("t5_in_ready", 32'(in_ready), 1);
        chk("t5_core_start", 32'(core_start), 0);
        chk("t5_core_rst", 32'(core_rst), 0);
        exp_q.delete();
        repeat (100) @(negedge clk);
        chk("t5_no_stale", 32'(got_q.size()), 32'(g0));
        got_rd = got_q.size();

        // 6: stale done during LDA/LDB ignored
        stale_en = 1'b1;
        n_lat = 3;
        push(9, 6, 1'b0);
        wait_results("t6_result", 1);
        stale_en = 1'b0;
        chk("t6_latency", 32'(vrise_cyc - lda_cyc), 32'(n_lat + 2));

        // 7: random pairs including zeros
        for (int i = 0; i < 10; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
            b = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 255));
            n_lat = int'($urandom_range(1, 8));
            push(a, b, 1'b0);
            wait_results("t7_random", 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
